tick_count_decoder: RTL and testbench

TICK_COUNT_DECODER -- requirements
Module: tick_count_decoder

---
 rtl/tick_count_decoder_if.sv | 28 ++
 rtl/tick_count_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_tick_count_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_count_decoder_if.sv
// Request/result bundle for the tick-count calendar decoder.
interface tick_count_decoder_if;
  logic        convReq;
  logic [63:0] tickCount;
  logic        busy;
  logic        done;
  logic [6:0]  millisecondsDisplay;
  logic [5:0]  timeInSeconds;
  logic [5:0]  timeInMinutesDisplay;
  logic [4:0]  timeInHoursDisplay;
  logic [5:0]  dateDisplay;
  logic [3:0]  monthDisplay;
  logic [13:0] yearDisplay;
  logic [2:0]  dayDisplay;
  logic        overflow;

  modport master (
    output convReq, tickCount,
    input  busy, done, millisecondsDisplay, timeInSeconds, timeInMinutesDisplay,
           timeInHoursDisplay, dateDisplay, monthDisplay, yearDisplay, dayDisplay, overflow
  );

  modport slave (
    input  convReq, tickCount,
    output busy, done, millisecondsDisplay, timeInSeconds, timeInMinutesDisplay,
           timeInHoursDisplay, dateDisplay, monthDisplay, yearDisplay, dayDisplay, overflow
  );
endinterface

// File: rtl/tick_count_decoder.sv
// Sequential decoder: 100 Hz tick count since the epoch -> calendar date,
// time of day and weekday. One shared restoring divider serves the day split
// and the h/m/s splits; years and months are peeled off one per cycle.
module tick_count_decoder #(
  parameter int EPOCH_YEAR = 1970,
  parameter int EPOCH_WDAY = 4
) (
  input logic                 clockSignal,
  input logic                 startOrStop,
  tick_count_decoder_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DIV_DAY = 3'd1;
  localparam logic [2:0] DIV_HMS = 3'd2;
  localparam logic [2:0] WDAY    = 3'd3;
  localparam logic [2:0] YEAR    = 3'd4;
  localparam logic [2:0] MONTH   = 3'd5;
  localparam logic [2:0] FINISH  = 3'd6;

  localparam logic [23:0] DAY_TICKS = 24'd8640000;
  localparam logic [13:0] YEAR_MAX  = 14'd16383;

  logic [2:0]  state;
  logic [6:0]  cnt;
  logic [1:0]  phase;
  logic [63:0] opnd;     // latched request operand, never modified while busy
  logic [23:0] rem;      // divider partial remainder
  logic [23:0] hdv;      // h/m/s dividend, shifts out MSB-first, quotient shifts in
  logic [40:0] days;     // day quotient, later the days still to be placed
  logic [42:0] wop;      // weekday operand, shifted MSB-first
  logic [2:0]  wr;       // running mod-7 remainder
  logic [4:0]  hrs_w;
  logic [5:0]  min_w;
  logic [5:0]  sec_w;
  logic [6:0]  cs_w;
  logic [13:0] year_w;
  logic [3:0]  mon_w;
  logic        ovf_w;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y[1:0] == 2'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

  logic        din;
  logic [23:0] dvsr;
  logic [24:0] trial;
  logic        ge;
  logic [23:0] rnext;
  logic [3:0]  wt;
  logic [2:0]  wnext;
  logic        leap_now;
  logic [8:0]  ylen;
  logic [4:0]  mlen;
  logic [23:0] hq;

  // One restoring-division step, one mod-7 step and the year/month lengths.
  always_comb begin
    din = (state == DIV_DAY) ? opnd[~cnt[5:0]] : hdv[23];
    dvsr = DAY_TICKS;
    if (state == DIV_HMS) begin
      case (phase)
        2'd0:    dvsr = 24'd360000;
        2'd1:    dvsr = 24'd6000;
        default: dvsr = 24'd100;
      endcase
    end
    trial = {rem, din};
    ge    = (trial >= {1'b0, dvsr});
    rnext = ge ? 24'(trial - {1'b0, dvsr}) : trial[23:0];
    hq    = {hdv[22:0], ge};

    wt    = {wr, wop[42]};
    wnext = (wt >= 4'd7) ? 3'(wt - 4'd7) : wt[2:0];

    leap_now = is_leap(year_w);
    ylen     = leap_now ? 9'd366 : 9'd365;
    case (mon_w)
      4'd2:                      mlen = leap_now ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mlen = 5'd30;
      default:                   mlen = 5'd31;
    endcase
  end

  // Conversion sequencer and working datapath.
  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= '0;
      opnd     <= '0;
      rem      <= '0;
      hdv      <= '0;
      days     <= '0;
      wop      <= '0;
      wr       <= '0;
      hrs_w    <= '0;
      min_w    <= '0;
      sec_w    <= '0;
      cs_w     <= '0;
      year_w   <= 14'(EPOCH_YEAR);
      mon_w    <= 4'd1;
      ovf_w    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle itself is not an accepting cycle.
          if (bus.convReq && !bus.done) begin
            opnd     <= bus.tickCount;
            bus.busy <= 1'b1;
            cnt      <= '0;
            rem      <= '0;
            days     <= '0;
            ovf_w    <= 1'b0;
            state    <= DIV_DAY;
          end
        end
        DIV_DAY: begin
          days <= {days[39:0], ge};
          rem  <= rnext;
          cnt  <= cnt + 7'd1;
          if (cnt == 7'd63) begin
            hdv   <= rnext;
            rem   <= '0;
            cnt   <= '0;
            phase <= '0;
            state <= DIV_HMS;
          end
        end
        DIV_HMS: begin
          hdv <= hq;
          rem <= rnext;
          cnt <= cnt + 7'd1;
          if (cnt == 7'd23) begin
            // Quotient goes to its field; remainder is the next dividend.
            case (phase)
              2'd0:    hrs_w <= hq[4:0];
              2'd1:    min_w <= hq[5:0];
              default: begin
                sec_w <= hq[5:0];
                cs_w  <= rnext[6:0];
              end
            endcase
            hdv   <= rnext;
            rem   <= '0;
            cnt   <= '0;
            phase <= phase + 2'd1;
            if (phase == 2'd2) begin
              wop   <= {2'b0, days} + 43'(EPOCH_WDAY);
              wr    <= '0;
              state <= WDAY;
            end
          end
        end
        WDAY: begin
          wr  <= wnext;
          wop <= {wop[41:0], 1'b0};
          cnt <= cnt + 7'd1;
          if (cnt == 7'd42) begin
            cnt    <= '0;
            year_w <= 14'(EPOCH_YEAR);
            state  <= YEAR;
          end
        end
        YEAR: begin
          if (days >= {32'd0, ylen}) begin
            if (year_w == YEAR_MAX) begin
              ovf_w <= 1'b1;
              state <= FINISH;
            end else begin
              days   <= days - {32'd0, ylen};
              year_w <= year_w + 14'd1;
            end
          end else begin
            mon_w <= 4'd1;
            state <= MONTH;
          end
        end
        MONTH: begin
          if (days >= {36'd0, mlen}) begin
            days  <= days - {36'd0, mlen};
            mon_w <= mon_w + 4'd1;
          end else begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers: loaded together on FINISH, held otherwise.
  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      bus.millisecondsDisplay  <= '0;
      bus.timeInSeconds        <= '0;
      bus.timeInMinutesDisplay <= '0;
      bus.timeInHoursDisplay   <= '0;
      bus.dayDisplay           <= '0;
      bus.dateDisplay          <= 6'd1;
      bus.monthDisplay         <= 4'd1;
      bus.yearDisplay          <= 14'(EPOCH_YEAR);
      bus.overflow             <= 1'b0;
    end else if (state == FINISH) begin
      bus.millisecondsDisplay  <= cs_w;
      bus.timeInSeconds        <= sec_w;
      bus.timeInMinutesDisplay <= min_w;
      bus.timeInHoursDisplay   <= hrs_w;
      bus.dayDisplay           <= wr;
      bus.overflow             <= ovf_w;
      bus.dateDisplay          <= ovf_w ? 6'd0  : ({1'b0, days[4:0]} + 6'd1);
      bus.monthDisplay         <= ovf_w ? 4'd0  : mon_w;
      bus.yearDisplay          <= ovf_w ? 14'd0 : year_w;
    end
  end
endmodule

// File: tb/tb_tick_count_decoder.sv
// Randomised bench for tick_count_decoder against a calendar reference model.
module tb_tick_count_decoder;
  localparam int EPOCH_YEAR = 1970;
  localparam int EPOCH_WDAY = 4;
  localparam int LIMIT      = 20000;

  logic clockSignal = 1'b0;
  logic startOrStop;
  int   checks   = 0;
  int   failures = 0;

  tick_count_decoder_if bus();

  tick_count_decoder #(.EPOCH_YEAR(EPOCH_YEAR), .EPOCH_WDAY(EPOCH_WDAY)) dut (
    .clockSignal(clockSignal),
    .startOrStop(startOrStop),
    .bus        (bus)
  );

  always #5 clockSignal = ~clockSignal;

  typedef struct {
    longint cs, s, mi, h, date, mon, yr, wd, lat;
    bit     ovf;
  } res_t;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit leap(input longint y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  // Calendar reference: plain arithmetic and a month-length table.
  function automatic res_t model(input longint unsigned t);
    res_t r;
    longint unsigned days, tod, left;
    longint y, m;
    longint ml[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    days  = t / 64'd8640000;
    tod   = t % 64'd8640000;
    r.h   = longint'(tod / 360000);
    r.mi  = longint'((tod % 360000) / 6000);
    r.s   = longint'((tod % 6000) / 100);
    r.cs  = longint'(tod % 100);
    r.wd  = longint'((days + EPOCH_WDAY) % 7);
    r.lat = 182;
    r.ovf = 0;
    left  = days;
    y     = EPOCH_YEAR;
    while (1) begin
      longint yl = leap(y) ? 366 : 365;
      if (left < longint'(yl)) break;
      if (y == 16383) begin r.ovf = 1; break; end
      left -= yl;
      y++;
      r.lat++;
    end
    if (r.ovf) begin
      r.date = 0; r.mon = 0; r.yr = 0;
    end else begin
      if (leap(y)) ml[1] = 29;
      m = 0;
      while (left >= longint'(ml[m])) begin
        left -= ml[m];
        m++;
        r.lat++;
      end
      r.date = longint'(left) + 1;
      r.mon  = m + 1;
      r.yr   = y;
    end
    return r;
  endfunction

  // Wait for done after the accepting edge; a stray request with a different
  // operand is injected mid-conversion and must have no effect.
  task automatic wait_done(output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < LIMIT) begin
      n++;
      bus.convReq   = (n == 10);
      bus.tickCount = {$urandom, $urandom};
      @(posedge clockSignal); #1;
      seen = bus.done;
    end
    bus.convReq = 1'b0;
    chk("done_seen", seen, 1);
    if (!seen) n = -1;
  endtask

  task automatic check_fields(input string tag, input res_t e);
    chk({tag, "_cs"},   bus.millisecondsDisplay,  e.cs);
    chk({tag, "_sec"},  bus.timeInSeconds,        e.s);
    chk({tag, "_min"},  bus.timeInMinutesDisplay, e.mi);
    chk({tag, "_hr"},   bus.timeInHoursDisplay,   e.h);
    chk({tag, "_date"}, bus.dateDisplay,          e.date);
    chk({tag, "_mon"},  bus.monthDisplay,         e.mon);
    chk({tag, "_yr"},   bus.yearDisplay,          e.yr);
    chk({tag, "_wday"}, bus.dayDisplay,           e.wd);
    chk({tag, "_ovf"},  bus.overflow,             e.ovf);
  endtask

  task automatic do_conv(input string tag, input longint unsigned t);
    res_t e;
    int   n;
    e = model(t);
    bus.convReq   = 1'b1;
    bus.tickCount = t;
    @(posedge clockSignal); #1;
    bus.convReq = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    wait_done(n);
    if (!e.ovf) chk({tag, "_lat"}, n, e.lat);
    check_fields(tag, e);
    @(posedge clockSignal); #1;
    chk({tag, "_pulse"}, bus.done, 0);
    chk({tag, "_idle"},  bus.busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ovf"},  bus.overflow, 0);
    chk({tag, "_time"}, {bus.millisecondsDisplay, bus.timeInSeconds,
                         bus.timeInMinutesDisplay, bus.timeInHoursDisplay}, 0);
    chk({tag, "_wday"}, bus.dayDisplay, 0);
    chk({tag, "_date"}, bus.dateDisplay, 1);
    chk({tag, "_mon"},  bus.monthDisplay, 1);
    chk({tag, "_yr"},   bus.yearDisplay, EPOCH_YEAR);
  endtask

  initial begin
    int   n, dones;
    res_t e;
    longint unsigned r, t2;

    startOrStop   = 1'b1;
    bus.convReq   = 1'b0;
    bus.tickCount = '0;
    repeat (3) @(posedge clockSignal);
    #1;
    check_reset_vals("rst");
    startOrStop = 1'b0;

    // First request right after release, epoch itself.
    do_conv("t0", 64'd0);
    chk("t0_date_c", {bus.yearDisplay, bus.monthDisplay, bus.dateDisplay},
        {14'd1970, 4'd1, 6'd1});
    chk("t0_wday_c", bus.dayDisplay, 4);

    do_conv("d1", 64'd8640000);
    chk("d1_date_c", bus.dateDisplay, 2);
    chk("d1_wday_c", bus.dayDisplay, 5);

    do_conv("leap", 64'd95182769678);
    chk("leap_date_c", {bus.yearDisplay, bus.monthDisplay, bus.dateDisplay},
        {14'd2000, 4'd2, 6'd29});
    chk("leap_time_c", {bus.timeInHoursDisplay, bus.timeInMinutesDisplay,
                        bus.timeInSeconds, bus.millisecondsDisplay},
        {5'd12, 6'd34, 6'd56, 7'd78});
    chk("leap_wday_c", bus.dayDisplay, 2);

    do_conv("y2100", 64'd410754240000);
    chk("y2100_date_c", {bus.yearDisplay, bus.monthDisplay, bus.dateDisplay},
        {14'd2100, 4'd3, 6'd1});
    chk("y2100_wday_c", bus.dayDisplay, 1);

    // Last tick of a common year and of a leap year.
    do_conv("dec70", 64'd365 * 64'd8640000 - 64'd1);
    do_conv("dec72", 64'd1096 * 64'd8640000 - 64'd1);

    do_conv("ones", 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones_ovf_c", bus.overflow, 1);
    chk("ones_cs_c", bus.millisecondsDisplay, 15);

    // Overflow flag must clear on the next normal conversion.
    do_conv("after_ovf", 64'd123456789);

    for (int i = 0; i < 15; i++) begin
      r = {$urandom, $urandom};
      case (i % 3)
        0:       do_conv("rnd", r % 64'd2000000000000);
        1:       do_conv("rnd_day", (r % 64'd200000) * 64'd8640000);
        default: do_conv("rnd_near", r % (64'd1900 * 64'd8640000));
      endcase
    end

    // Request held through the done cycle: ignored there, accepted next edge.
    bus.convReq   = 1'b1;
    bus.tickCount = 64'd5000000000;
    @(posedge clockSignal); #1;
    bus.convReq = 1'b0;
    wait_done(n);
    t2 = 64'd777777777777;
    e  = model(t2);
    bus.convReq   = 1'b1;
    bus.tickCount = t2;
    @(posedge clockSignal); #1;
    chk("donecyc_ignored", bus.busy, 0);
    @(posedge clockSignal); #1;
    bus.convReq = 1'b0;
    chk("donecyc_accept", bus.busy, 1);
    wait_done(n);
    chk("donecyc_lat", n, e.lat);
    check_fields("donecyc", e);

    // Results hold while idle.
    repeat (25) @(posedge clockSignal);
    #1;
    check_fields("hold", e);

    // Reset 50 cycles into a conversion.
    bus.convReq   = 1'b1;
    bus.tickCount = 64'd95182769678;
    @(posedge clockSignal); #1;
    bus.convReq = 1'b0;
    repeat (50) @(posedge clockSignal);
    #1;
    chk("mid_busy", bus.busy, 1);
    startOrStop = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clockSignal); #1;
    startOrStop = 1'b0;
    dones = 0;
    repeat (400) begin
      @(posedge clockSignal); #1;
      if (bus.done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    do_conv("post_rst", 64'd95182769678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
